// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants and state encoding for the channel scan sequencer
package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/scan_sequencer_next_ch_find.sv
// rtl/scan_sequencer_next_ch_find.sv - combinational search for the next and the first enabled channel
module next_ch_find
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic              nxt_found,
  output logic [SEL_W-1:0]  first,
  output logic              any
);

  // Scan from the top index down so the lowest qualifying index is the last one written.
  always_comb begin
    nxt       = '0;
    nxt_found = 1'b0;
    first     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) begin
        nxt       = SEL_W'(i);
        nxt_found = 1'b1;
      end
      if (mask[i]) begin
        first = SEL_W'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - dwell-timed channel select sequencer; optional inter-channel gap via SCAN_BLANK_EN
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_CYCLES = 16,
  parameter int CNT_W        = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  output logic              busy,
  output logic              sweep_done
);

  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] nxt;
  logic             nxt_found;
  logic [SEL_W-1:0] first;
  logic             any;

  // The search always looks relative to the channel currently on the decoder.
  next_ch_find u_find (
    .mask      (mask),
    .cur       (sel),
    .nxt       (nxt),
    .nxt_found (nxt_found),
    .first     (first),
    .any       (any)
  );

  // Parameter sanity: both hold periods need at least one cycle and must fit the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (DWELL_CYCLES >= 1 && BLANK_CYCLES >= 1 &&
              (DWELL_CYCLES - 1) < (2 ** CNT_W) && (BLANK_CYCLES - 1) < (2 ** CNT_W));
    end
  end

  // Scan FSM: dwell counter, channel select and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel        <= '0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (any) begin
              state     <= ST_DWELL;
              sel       <= first;
              sel_valid <= 1'b1;
              busy      <= 1'b1;
              cnt       <= '0;
            end else begin
              // An empty mask is a complete, zero-length sweep.
              sweep_done <= 1'b1;
            end
          end
        end

        ST_DWELL: begin
          if (stop) begin
            state     <= ST_IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
          end else if (cnt == DWELL_END) begin
            cnt <= '0;
            if (nxt_found) begin
              sel <= nxt;
`ifdef SCAN_BLANK_EN
              state     <= ST_BLANK;
              sel_valid <= 1'b0;
`endif
            end else if (continuous && any) begin
              // Wrap: end of pass is reported even though scanning carries on.
              sweep_done <= 1'b1;
              sel        <= first;
`ifdef SCAN_BLANK_EN
              state     <= ST_BLANK;
              sel_valid <= 1'b0;
`endif
            end else begin
              // One-shot end, or the mask was emptied while dwelling.
              sweep_done <= 1'b1;
              state      <= ST_IDLE;
              sel_valid  <= 1'b0;
              busy       <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          if (stop) begin
            state     <= ST_IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
          end else if (cnt == BLANK_END) begin
            state     <= ST_DWELL;
            sel_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: begin
          state     <= ST_IDLE;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized self-checking bench for scan_sequencer against a trace model
module tb_scan_sequencer;

  localparam int DWELL = 16;
  localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       sweep_done;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   chan_q[$];
  logic [2:0] model_sel;

  scan_sequencer #(
    .DWELL_CYCLES (DWELL),
    .CNT_W        (8),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .mask       (mask),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int ch, input bit v, input bit b, input bit d);
    exp_t e;
    e.sel   = 3'(ch);
    e.valid = v;
    e.busy  = b;
    e.done  = d;
    return e;
  endfunction

  task automatic check_entry(input exp_t e, input string tag);
    check({tag, ".sel"},        int'(sel),        int'(e.sel));
    check({tag, ".sel_valid"},  int'(sel_valid),  int'(e.valid));
    check({tag, ".busy"},       int'(busy),       int'(e.busy));
    check({tag, ".sweep_done"}, int'(sweep_done), int'(e.done));
    model_sel = e.sel;
  endtask

  // Enabled channels in ascending order.
  task automatic load_mask(input logic [7:0] m);
    chan_q.delete();
    for (int i = 0; i < 8; i++) if (m[i]) chan_q.push_back(i);
  endtask

  // Expected per-cycle outputs for nsweeps passes over chan_q, starting on the sample after start.
  task automatic build(input int nsweeps, input bit end_idle);
    bit pend;
    bit first_ch;
    int last;
    exp_q.delete();
    pend     = 1'b0;
    first_ch = 1'b1;
    last     = int'(model_sel);
    if (chan_q.size() != 0) begin
      for (int s = 0; s < nsweeps; s++) begin
        foreach (chan_q[k]) begin
          if (!first_ch && BLANK_ON) begin
            for (int b = 0; b < BLANK; b++) begin
              exp_q.push_back(mk(chan_q[k], 1'b0, 1'b1, pend));
              pend = 1'b0;
            end
          end
          for (int d = 0; d < DWELL; d++) begin
            exp_q.push_back(mk(chan_q[k], 1'b1, 1'b1, pend));
            pend = 1'b0;
          end
          first_ch = 1'b0;
          last     = chan_q[k];
        end
        pend = 1'b1;
      end
    end
    if (end_idle || chan_q.size() == 0) begin
      exp_q.push_back(mk(last, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(last, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // Pulse start, then compare every sample with the trace; optional stop and mid-run mask change.
  task automatic run(input logic [7:0] m, input bit cont, input int stop_at,
                     input int chg_at, input logic [7:0] m2, input string tag);
    mask       = m;
    continuous = cont;
    start      = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == stop_at) stop = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      if (i == stop_at) begin
        check_entry(mk(int'(model_sel), 1'b0, 1'b0, 1'b0), {tag, ".stopped"});
        step();
        check_entry(mk(int'(model_sel), 1'b0, 1'b0, 1'b0), {tag, ".stopped_idle"});
        return;
      end
      check_entry(exp_q[i], tag);
      if (i == chg_at) mask = m2;
      start = exp_q[i].busy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  initial begin
    logic [7:0] m;
    int         mode;
    int         sa;

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; mask = 8'h00;
    model_sel = 3'd0;
    repeat (3) step();
    check_entry(mk(0, 1'b0, 1'b0, 1'b0), "reset");
    rst = 1'b0;
    step();

    // one-shot sweep over 0,2,5,7
    load_mask(8'hA5); build(1, 1'b1);
    run(8'hA5, 1'b0, -1, -1, 8'hA5, "oneshot_a5");

    // continuous 0,7 round robin, stopped partway through the fourth pass
    load_mask(8'h81); build(4, 1'b0);
    run(8'h81, 1'b1, exp_q.size() - 5, -1, 8'h81, "cont_81");

    // empty mask: immediate sweep_done, no valid
    load_mask(8'h00); build(1, 1'b1);
    run(8'h00, 1'b0, -1, -1, 8'h00, "empty_mask");

    // stop mid-dwell on channel 2
    load_mask(8'h0C); build(1, 1'b1);
    run(8'h0C, 1'b0, 5, -1, 8'h0C, "stop_mid");

    // start and stop together in IDLE: stop wins
    mask = 8'h0C; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_entry(mk(int'(model_sel), 1'b0, 1'b0, 1'b0), "start_stop");
    step();
    check_entry(mk(int'(model_sel), 1'b0, 1'b0, 1'b0), "start_stop_idle");

    // stop landing exactly on the last advance point: no sweep_done
    load_mask(8'h06); build(1, 1'b1);
    run(8'h06, 1'b0, exp_q.size() - 2, -1, 8'h06, "stop_at_end");

    // mask 0F -> 09 during channel 1: channel 1 completes, channel 2 skipped
    chan_q.delete(); chan_q.push_back(0); chan_q.push_back(1); chan_q.push_back(3);
    build(1, 1'b1);
    run(8'h0F, 1'b0, -1, DWELL + 3, 8'h09, "mask_change");

    // continuous, mask emptied mid-dwell: ends the sweep and goes idle
    chan_q.delete(); chan_q.push_back(0);
    build(1, 1'b1);
    run(8'h01, 1'b1, -1, 3, 8'h00, "cont_mask_empty");

    // single channel continuous: constant sel, pulse every pass
    load_mask(8'h10); build(3, 1'b0);
    run(8'h10, 1'b1, exp_q.size() - 1, -1, 8'h10, "cont_single");

    // reset in the middle of a sweep
    mask = 8'hA5; continuous = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_sel = 3'd0;
    check_entry(mk(0, 1'b0, 1'b0, 1'b0), "reset_mid");
    step();
    check_entry(mk(0, 1'b0, 1'b0, 1'b0), "reset_mid_idle");

    // randomized sweeps
    for (int it = 0; it < 16; it++) begin
      m = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) m = 8'h00;
      mode = int'($urandom_range(0, 2));
      load_mask(m);
      if (mode == 0) begin
        build(1, 1'b1);
        run(m, 1'b0, -1, -1, m, "rnd_oneshot");
      end else if (mode == 1) begin
        build(1, 1'b1);
        sa = (chan_q.size() != 0) ? int'($urandom_range(1, exp_q.size() - 2)) : -1;
        run(m, 1'b0, sa, -1, m, "rnd_stop");
      end else begin
        build(3, 1'b0);
        sa = (chan_q.size() != 0) ? int'($urandom_range(1, exp_q.size() - 1)) : -1;
        run(m, 1'b1, sa, -1, m, "rnd_cont");
      end
      repeat ($urandom_range(0, 3)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
